// File: rtl/song_sequencer.sv
// song_sequencer: writable multi-song note table with a pausable, loopable playback FSM
module song_sequencer #(
    parameter int NUM_SONGS  = 4,
    parameter int MAX_NOTES  = 32,
    parameter int NOTE_W     = 5,
    parameter int DUR_W      = 27,
    parameter int GAP_CYCLES = 2500000,
    localparam int SONG_W    = $clog2(NUM_SONGS),
    localparam int IDX_W     = $clog2(MAX_NOTES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [SONG_W-1:0] wr_song,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [NOTE_W-1:0] wr_note,
    input  logic [DUR_W-1:0]  wr_dur,
    input  logic [SONG_W-1:0] song_sel,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              loop_en,
    output logic [NOTE_W-1:0] note,
    output logic              note_on,
    output logic [IDX_W-1:0]  note_index,
    output logic              busy,
    output logic              done
);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int CNT_W = DUR_W > GAP_W ? DUR_W : GAP_W;
    typedef enum logic [2:0] {IDLE, FETCH, PLAY, GAP, PAUSED} state_t;
    state_t state_q, state_d, saved_q, saved_d, eff;
    logic [SONG_W-1:0] song_q, song_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NOTE_W-1:0] note_q, note_d;
    logic              done_q, done_d, fin;
    logic [NOTE_W-1:0] note_mem [NUM_SONGS][MAX_NOTES];
    logic [DUR_W-1:0]  dur_mem  [NUM_SONGS][MAX_NOTES];

    always_ff @(posedge clk)
        if (wr_en) begin
            note_mem[wr_song][wr_idx] <= wr_note;
            dur_mem[wr_song][wr_idx]  <= wr_dur;
        end

    // Releasing pause resumes the saved state in the same cycle, so no extra silent cycle is added.
    assign eff = (state_q == PAUSED && !pause) ? saved_q : state_q;

    always_ff @(posedge clk)
        if (rst) begin
            state_q <= IDLE;
            saved_q <= IDLE;
            song_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            note_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            song_q  <= song_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            note_q  <= note_d;
            done_q  <= done_d;
        end

    always_comb begin
        state_d = eff;
        saved_d = saved_q;
        song_d  = song_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        note_d  = note_q;
        done_d  = 1'b0;
        fin     = 1'b0;
        if (stop)
            state_d = IDLE;
        else if (pause && (eff == PLAY || eff == GAP)) begin
            state_d = PAUSED;
            saved_d = eff;
        end else
            case (eff)
                IDLE:
                    if (start) begin
                        song_d  = song_sel;
                        idx_d   = '0;
                        state_d = FETCH;
                    end
                FETCH:
                    if (dur_mem[song_q][idx_q] == '0)
                        fin = 1'b1;
                    else begin
                        cnt_d   = CNT_W'(dur_mem[song_q][idx_q]) - CNT_W'(1);
                        note_d  = note_mem[song_q][idx_q];
                        state_d = PLAY;
                    end
                PLAY:
                    if (cnt_q == '0) begin
                        cnt_d   = CNT_W'(GAP_CYCLES - 1);
                        state_d = GAP;
                    end else
                        cnt_d = cnt_q - CNT_W'(1);
                GAP:
                    if (cnt_q != '0)
                        cnt_d = cnt_q - CNT_W'(1);
                    else if (idx_q == IDX_W'(MAX_NOTES - 1))
                        fin = 1'b1;
                    else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = FETCH;
                    end
                default: ;
            endcase
        if (fin) begin
            idx_d   = '0;
            state_d = loop_en ? FETCH : IDLE;
            done_d  = !loop_en;
        end
    end

    always_comb begin
        note_on    = eff == PLAY && !pause;
        busy       = state_q != IDLE;
        note       = note_q;
        note_index = idx_q;
        done       = done_q;
    end
endmodule

// File: tb/tb_song_sequencer.sv
// tb_song_sequencer: directed cycle-exact checks of load, playback, loop, pause, stop and reset
module tb_song_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic       wr_song = 1'b0;
    logic [1:0] wr_idx = '0;
    logic [4:0] wr_note = '0;
    logic [7:0] wr_dur = '0;
    logic       song_sel = 1'b0;
    logic       start = 1'b0, stop = 1'b0, pause = 1'b0, loop_en = 1'b0;
    logic [4:0] note;
    logic       note_on, busy, done;
    logic [1:0] note_index;
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    song_sequencer #(.NUM_SONGS(2), .MAX_NOTES(4), .NOTE_W(5), .DUR_W(8), .GAP_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_song(wr_song), .wr_idx(wr_idx),
        .wr_note(wr_note), .wr_dur(wr_dur), .song_sel(song_sel), .start(start), .stop(stop),
        .pause(pause), .loop_en(loop_en), .note(note), .note_on(note_on),
        .note_index(note_index), .busy(busy), .done(done)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic s, input logic [1:0] i, input logic [4:0] n, input logic [7:0] d);
        wr_en = 1'b1; wr_song = s; wr_idx = i; wr_note = n; wr_dur = d;
        tick;
        wr_en = 1'b0;
    endtask

    task automatic go(input logic s);
        song_sel = s; start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) tick;
        rst = 1'b0;
        tests++;
        if ({note, note_on, note_index, busy, done} !== 10'b0) begin
            fails++;
            $display("FAIL reset outputs got %b want 0", {note, note_on, note_index, busy, done});
        end
    endtask

    task automatic test_play;
        logic on_e, done_e, busy_e;
        wr(1'b0, 2'd0, 5'd3, 8'd5);
        wr(1'b0, 2'd1, 5'd7, 8'd2);
        wr(1'b0, 2'd2, 5'd1, 8'd0);
        go(1'b0);
        for (int k = 1; k <= 16; k++) begin
            on_e = (k >= 2 && k <= 6) || (k >= 10 && k <= 11);
            done_e = k == 15;
            busy_e = k <= 14;
            tests++;
            if ({note_on, done, busy} !== {on_e, done_e, busy_e}) begin
                fails++;
                $display("FAIL play k=%0d on/done/busy got %b want %b", k, {note_on, done, busy}, {on_e, done_e, busy_e});
            end
            if (k == 2 || k == 10) begin
                tests++;
                if (note !== (k == 2 ? 5'd3 : 5'd7)) begin
                    fails++;
                    $display("FAIL play_note k=%0d got %0d want %0d", k, note, k == 2 ? 3 : 7);
                end
            end
            tick;
        end
    endtask

    task automatic test_wrap;
        for (int i = 0; i < 4; i++) wr(1'b1, 2'(i), 5'(10 + i), 8'd1);
        go(1'b1);
        for (int k = 1; k <= 20; k++) begin
            tests++;
            if ({note_on, done, busy} !== {k == 2 || k == 6 || k == 10 || k == 14, k == 17, k <= 16}) begin
                fails++;
                $display("FAIL wrap k=%0d on/done/busy got %b want %b", k, {note_on, done, busy},
                         {k == 2 || k == 6 || k == 10 || k == 14, k == 17, k <= 16});
            end
            if (k == 14) begin
                tests++;
                if ({note, note_index} !== {5'd13, 2'd3}) begin
                    fails++;
                    $display("FAIL wrap_last note/index got %0d/%0d want 13/3", note, note_index);
                end
            end
            tick;
        end
    endtask

    task automatic test_loop;
        int dones = 0;
        loop_en = 1'b1;
        go(1'b0);
        for (int k = 1; k <= 16; k++) begin
            dones += int'(done);
            if (k == 15) begin
                tests++;
                if ({busy, note_index} !== {1'b1, 2'd0}) begin
                    fails++;
                    $display("FAIL loop_restart busy/index got %b/%0d want 1/0", busy, note_index);
                end
            end
            if (k == 16) begin
                tests++;
                if ({note_on, note, note_index} !== {1'b1, 5'd3, 2'd0}) begin
                    fails++;
                    $display("FAIL loop_replay on/note/index got %b/%0d/%0d want 1/3/0", note_on, note, note_index);
                end
            end
            tick;
        end
        tests++;
        if (dones != 0) begin
            fails++;
            $display("FAIL loop_done got %0d pulses want 0", dones);
        end
        loop_en = 1'b0;
        stop = 1'b1;
        tick;
        stop = 1'b0;
    endtask

    task automatic test_pause;
        int highs = 0;
        go(1'b0);
        repeat (3) tick;
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            tests++;
            if ({note_on, busy} !== 2'b01) begin
                fails++;
                $display("FAIL pause i=%0d on/busy got %b want 01", i, {note_on, busy});
            end
            tick;
        end
        pause = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            highs += int'(note_on);
            tests++;
            if (note_on !== (i < 3)) begin
                fails++;
                $display("FAIL resume i=%0d note_on got %b want %b", i, note_on, i < 3);
            end
            tick;
        end
        tests++;
        if (highs != 3) begin
            fails++;
            $display("FAIL resume_total got %0d want 3", highs);
        end
        stop = 1'b1;
        tick;
        stop = 1'b0;
    endtask

    task automatic test_stop;
        int dones = 0;
        go(1'b0);
        tick;
        song_sel = 1'b1; start = 1'b1;
        tick;
        start = 1'b0;
        tests++;
        if ({note_on, note} !== {1'b1, 5'd3}) begin
            fails++;
            $display("FAIL start_while_busy on/note got %b/%0d want 1/3", note_on, note);
        end
        stop = 1'b1;
        tick;
        stop = 1'b0;
        tests++;
        if ({note_on, busy, done} !== 3'b000) begin
            fails++;
            $display("FAIL stop on/busy/done got %b want 000", {note_on, busy, done});
        end
        start = 1'b1; stop = 1'b1;
        tick;
        start = 1'b0; stop = 1'b0;
        for (int k = 0; k < 6; k++) begin
            dones += int'(done | busy | note_on);
            tick;
        end
        tests++;
        if (dones != 0) begin
            fails++;
            $display("FAIL start_stop_idle activity got %0d cycles want 0", dones);
        end
    endtask

    task automatic test_empty_reset;
        wr(1'b1, 2'd0, 5'd9, 8'd0);
        go(1'b1);
        tests++;
        if ({done, busy, note_on} !== 3'b010) begin
            fails++;
            $display("FAIL empty_fetch done/busy/on got %b want 010", {done, busy, note_on});
        end
        tick;
        tests++;
        if ({done, busy, note_on} !== 3'b100) begin
            fails++;
            $display("FAIL empty_done done/busy/on got %b want 100", {done, busy, note_on});
        end
        tick;
        tests++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL empty_done_width got %b want 0", done);
        end
        go(1'b0);
        repeat (10) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        tests++;
        if ({note, note_on, note_index, busy, done} !== 10'b0) begin
            fails++;
            $display("FAIL midplay_reset outputs got %b want 0", {note, note_on, note_index, busy, done});
        end
        go(1'b0);
        for (int k = 1; k <= 10; k++) begin
            if (k == 2 || k == 10) begin
                tests++;
                if ({note_on, note} !== {1'b1, k == 2 ? 5'd3 : 5'd7}) begin
                    fails++;
                    $display("FAIL table_kept k=%0d on/note got %b/%0d want 1/%0d", k, note_on, note, k == 2 ? 3 : 7);
                end
            end
            tick;
        end
    endtask

    initial begin
        test_reset;
        test_play;
        test_wrap;
        test_loop;
        test_pause;
        test_stop;
        test_empty_reset;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
